inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Dual-slot instruction buffer between the fetch stage and the two ID decoders. Accepts up to two fetched {PC, instruction} pairs per cycle, stores them in program order in a circular buffer, and presents the two oldest entries to decoder slots 0 and 1 with per-slot valids. Decouples fetch from ID stalls and discards all buffered work on a pipeline flush (branch redirect).

## Interface
- DEPTH, 8, number of entries; power of two, ≥4
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (redirect from EX)
- in_valid  in  2  fetch slot valids; [0] older; [1] honoured only with [0]
- in_pc0, in_pc1  in  32  fetch PCs
- in_inst0, in_inst1  in  32  fetch instruction words
- in_ready  out  1  queue can take a full 2-slot push this cycle
- out_valid  out  2  [0] entry at head valid, [1] head+1 valid
- out_pc0, out_pc1  out  32  PC to decoder slot 0/1 (drives PC port)
- out_inst0, out_inst1  out  32  instruction to decoder slot 0/1 (drives IF_IR)
- pop  in  2  number of entries consumed by ID this cycle (0,1,2; 3 illegal → treated as 2)
- count  out  CW  current occupancy

## Operation
- Storage: DEPTH × 64-bit registers, head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Push: when in_ready & in_valid[0]; writes slot0 at tail, slot1 at tail+1 if in_valid[1]; tail += 1 or 2. in_valid = 2'b10 is ignored (no write).
- in_ready = (DEPTH − count ≥ 2), computed from registered count only (pop in same cycle not credited).
- Pop: effective pop = min(pop, count) (clipped, never underflows); head += effective pop.
- Outputs: out_valid[0] = count≥1, out_valid[1] = count≥2; out_*0 = entry[head], out_*1 = entry[head+1 mod DEPTH]. Slot order always preserved: slot1 never valid without slot0.
- Simultaneous push and pop: count_next = count + pushed − popped; both pointers update same cycle.
- Flush: head, tail, count ← 0 next edge; same-cycle push and pop discarded; flush has priority over everything.
- Entry contents not cleared by flush; invalid slots drive stale data, decoders must qualify with out_valid (data_valid).

## Timing
- Reset (rstn low, async): head=tail=count=0, all entries 0, out_valid=2'b00, out_pc*/out_inst*=0, in_ready=1.
- Push-to-output latency: 1 cycle (entry written on edge N visible on outputs after edge N).
- in_ready, out_valid, count, out_* depend only on registers (no combinational input→output path) unless IFQ_BYPASS_EN.
- Full: count ≥ DEPTH−1 deasserts in_ready; queue never overflows.
- Reset released mid-stream: first push accepted on first edge with rstn high.

## Configuration
- IFQ_BYPASS_EN defined: when count==0 and a push is accepted, out_valid/out_pc*/out_inst* reflect in_* combinationally that cycle; entries popped in the same cycle are not written (tail advances only by pushed−popped beyond bypass). flush still kills bypass (out_valid=0 when flush).
- Not defined: strict 1-cycle latency, all outputs registered-only.

## Test plan
- Reset: assert rstn=0 mid-push → next cycle count=0, out_valid=00, in_ready=1, out_pc0=0.
- Dual push in_valid=11, pc 0x1c000000/0x1c000004, pop=0 → next cycle out_valid=11, out_pc0=0x1c000000, out_pc1=0x1c000004, count=2.
- Fill DEPTH=8 with four dual pushes, pop=0 → in_ready=0 at count=7/8; extra push ignored, count stays 8, FIFO order intact on drain.
- Wrap: alternate push 2/pop 2 for 10 cycles → PCs emerge strictly sequential across pointer wrap, count constant 2.
- Flush with simultaneous push=11 and pop=1 at count=5 → next cycle count=0, out_valid=00; following push appears alone.
- pop=2 with count=1 → count=0, head+1 only; with IFQ_BYPASS_EN, push into empty queue shows out_valid=01 same cycle.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: dual-slot in-order instruction buffer between fetch and the
// two ID decoders. Circular buffer of DEPTH {pc, inst} entries. Up to two
// entries are pushed and up to two are popped per cycle. A flush drops
// everything that is buffered.
// Optional feature: define IFQ_BYPASS_EN to let an empty queue forward the
// incoming pair to the decoder outputs in the same cycle.
module inst_fetch_queue #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic [1:0]    in_valid,
  input  logic [31:0]   in_pc0,
  input  logic [31:0]   in_pc1,
  input  logic [31:0]   in_inst0,
  input  logic [31:0]   in_inst1,
  output logic          in_ready,
  output logic [1:0]    out_valid,
  output logic [31:0]   out_pc0,
  output logic [31:0]   out_pc1,
  output logic [31:0]   out_inst0,
  output logic [31:0]   out_inst1,
  input  logic [1:0]    pop,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_ok;
  logic          bypass;
  logic [1:0]    push_n;
  logic [1:0]    pop_req;
  logic [1:0]    pop_eff;
  logic [1:0]    byp_n;
  logic [1:0]    wr_n;
  logic [63:0]   in_ent0, in_ent1;
  logic [63:0]   rd0, rd1;

  assign in_ent0  = {in_pc0, in_inst0};
  assign in_ent1  = {in_pc1, in_inst1};
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;

  // Work out how many entries are accepted, how many are consumed from storage,
  // and how many are consumed directly from the bypass path.
  always_comb begin
    push_ok = in_ready & in_valid[0] & ~flush;
    push_n  = push_ok ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    pop_req = (pop == 2'd3) ? 2'd2 : pop;
    pop_eff = (count_q < CW'(pop_req)) ? count_q[1:0] : pop_req;
    bypass  = 1'b0;
`ifdef IFQ_BYPASS_EN
    bypass  = push_ok && (count_q == '0);
`endif
    byp_n   = '0;
    if (bypass) begin
      byp_n = (pop_req < push_n) ? pop_req : push_n;
    end
    wr_n    = push_n - byp_n;
  end

  // Compute the next pointer and occupancy values. Flush overrides all updates.
  always_comb begin
    head_d  = head_q + PW'(pop_eff);
    tail_d  = tail_q + PW'(wr_n);
    count_d = count_q + CW'(wr_n) - CW'(pop_eff);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Write the entries that were not consumed through the bypass path. If one
  // entry was bypassed, slot 1 is the entry that lands at the tail.
  always_comb begin
    mem_d = mem_q;
    if (wr_n != 2'd0) begin
      mem_d[tail_q] = (byp_n == 2'd0) ? in_ent0 : in_ent1;
    end
    if (wr_n == 2'd2) begin
      mem_d[tail_q + PW'(1)] = in_ent1;
    end
  end

  // State registers and storage. Reset clears the entries as well.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Drive the decoder slots from the two oldest entries, or from the inputs
  // when the bypass path is active.
  always_comb begin
    rd0       = mem_q[head_q];
    rd1       = mem_q[head_q + PW'(1)];
    out_valid = {count_q >= CW'(2), count_q != '0};
`ifdef IFQ_BYPASS_EN
    if (bypass) begin
      out_valid = (push_n == 2'd2) ? 2'b11 : 2'b01;
      rd0       = in_ent0;
      rd1       = in_ent1;
    end
    if (flush) begin
      out_valid = '0;
    end
`endif
    out_pc0   = rd0[63:32];
    out_inst0 = rd0[31:0];
    out_pc1   = rd1[63:32];
    out_inst1 = rd1[31:0];
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (default build, no bypass).
// The reference model is a queue of {pc, inst} entries.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    in_valid = '0;
  logic [1:0]    pop = '0;
  logic [31:0]   in_pc0 = '0, in_pc1 = '0, in_inst0 = '0, in_inst1 = '0;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [31:0]   out_pc0, out_pc1, out_inst0, out_inst1;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc0    (in_pc0),
    .in_pc1    (in_pc1),
    .in_inst0  (in_inst0),
    .in_inst1  (in_inst1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc0   (out_pc0),
    .out_pc1   (out_pc1),
    .out_inst0 (out_inst0),
    .out_inst1 (out_inst1),
    .pop       (pop),
    .count     (count)
  );

  logic [63:0] mq[$];
  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  logic [31:0] pc_gen   = 32'h1c00_0000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int unsigned n;
    n = mq.size();
    check_eq("count", 64'(count), 64'(n));
    check_eq("in_ready", 64'(in_ready), 64'((DEPTH - n) >= 2));
    check_eq("out_valid", 64'(out_valid), {62'b0, n >= 2, n >= 1});
    if (n >= 1) check_eq("slot0", {out_pc0, out_inst0}, mq[0]);
    if (n >= 2) check_eq("slot1", {out_pc1, out_inst1}, mq[1]);
  endtask

  // One clock cycle: drive the inputs, advance the model on the edge, and check afterwards.
  task automatic step(input logic f, input logic [1:0] v, input logic [1:0] p);
    logic [63:0] e0, e1;
    int unsigned n, pr;
    flush    = f;
    in_valid = v;
    pop      = p;
    in_pc0   = pc_gen;
    in_pc1   = pc_gen + 32'd4;
    in_inst0 = $urandom;
    in_inst1 = $urandom;
    e0 = {in_pc0, in_inst0};
    e1 = {in_pc1, in_inst1};
    n  = mq.size();
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      pr = (p == 2'd3) ? 2 : int'(p);
      if (pr > n) pr = n;
      repeat (pr) void'(mq.pop_front());
      if (v[0] && (DEPTH - n) >= 2) begin
        mq.push_back(e0);
        pc_gen += 32'd4;
        if (v[1]) begin
          mq.push_back(e1);
          pc_gen += 32'd4;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    // power-on reset
    #12;
    check_outputs();
    check_eq("rst_pc0", 64'(out_pc0), 64'd0);
    rstn = 1'b1;

    // first dual push
    step(1'b0, 2'b11, 2'd0);
    check_eq("pc0_first", 64'(out_pc0), 64'h1c00_0000);
    check_eq("pc1_first", 64'(out_pc1), 64'h1c00_0004);

    // fill to full, then try one more push, then drain
    step(1'b0, 2'b11, 2'd0);
    step(1'b0, 2'b11, 2'd0);
    step(1'b0, 2'b11, 2'd0);
    check_eq("full_count", 64'(count), 64'd8);
    step(1'b0, 2'b11, 2'd0);
    step(1'b0, 2'b01, 2'd0);
    step(1'b0, 2'b00, 2'd1);
    check_eq("ready_at7", 64'(in_ready), 64'd0);
    repeat (4) step(1'b0, 2'b00, 2'd2);

    // wrap test: keep count at 2 while pushing and popping
    step(1'b0, 2'b11, 2'd0);
    repeat (10) step(1'b0, 2'b11, 2'd2);

    // flush at count 5 with a simultaneous push and pop
    step(1'b0, 2'b11, 2'd0);
    step(1'b0, 2'b01, 2'd0);
    check_eq("pre_flush", 64'(count), 64'd5);
    step(1'b1, 2'b11, 2'd1);
    step(1'b0, 2'b01, 2'd0);
    step(1'b0, 2'b00, 2'd2);
    check_eq("pop_clip", 64'(count), 64'd0);
    step(1'b0, 2'b10, 2'd3);

    // reset while a push is being driven
    step(1'b0, 2'b11, 2'd0);
    in_valid = 2'b11;
    #2 rstn = 1'b0;
    #1 mq.delete();
    check_outputs();
    check_eq("midrst_pc0", 64'(out_pc0), 64'd0);
    @(posedge clk); #1;
    check_outputs();
    #3 rstn = 1'b1;
    step(1'b0, 2'b11, 2'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 31) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
